// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and click codes for the key click decoder
package key_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;
    localparam logic [1:0] CLICK_SINGLE = 2'd1;
    localparam logic [1:0] CLICK_DOUBLE = 2'd2;
    localparam logic [1:0] CLICK_TRIPLE = 2'd3;
    localparam logic [1:0] MAX_CLICKS   = 2'd3;
endpackage

// File: rtl/key_click_decoder.sv
// key_click_decoder: groups debounced key presses into single/double/triple clicks
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   key_flag           : one-cycle debounced press pulse
//   click_valid        : one-cycle pulse when a click sequence completes
//   click_num          : click count of that sequence (0 when click_valid is low)
//   busy               : a sequence is open
module key_click_decoder
    import key_pkg::*;
#(
    parameter logic [24:0] CNT_GAP = 25'd24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag,
    output logic       click_valid,
    output logic [1:0] click_num,
    output logic       busy
);
    state_t      state, state_nxt;
    logic [24:0] cnt_gap;
    logic [1:0]  click_cnt;
    logic        gap_done;

    assign gap_done = cnt_gap == CNT_GAP;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // a press in the same cycle as window expiry keeps the sequence open
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = key_flag ? WAIT : IDLE;
        else               state_nxt = (!key_flag && gap_done) ? IDLE : WAIT;
    end

    always_comb busy = state == WAIT;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_gap     <= '0;
            click_cnt   <= '0;
            click_valid <= 1'b0;
            click_num   <= '0;
        end else begin
            click_valid <= 1'b0;
            click_num   <= '0;
            if (state == IDLE) begin
                cnt_gap   <= '0;
                click_cnt <= key_flag ? CLICK_SINGLE : 2'd0;
            end else if (key_flag) begin
                cnt_gap   <= '0;
                click_cnt <= (click_cnt == MAX_CLICKS) ? click_cnt : click_cnt + 2'd1;
            end else if (!gap_done) begin
                cnt_gap <= cnt_gap + 25'd1;
            end else begin
                click_valid <= 1'b1;
                click_num   <= click_cnt;
                cnt_gap     <= '0;
                click_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: directed self-checking bench for key_click_decoder with CNT_GAP=10
module tb_key_click_decoder;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_flag = 1'b0;
    logic       click_valid;
    logic [1:0] click_num;
    logic       busy;
    int         tests = 0;
    int         fails = 0;

    always #5 sys_clk = ~sys_clk;

    key_click_decoder #(.CNT_GAP(25'd10)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_flag   (key_flag),
        .click_valid(click_valid),
        .click_num  (click_num),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, {31'd0, click_valid}, 0);
        chk({tag, " num"}, {30'd0, click_num}, 0);
        chk({tag, " busy"}, {31'd0, busy}, 0);
    endtask

    // drive kf into the next edge, sample 1 time unit after it
    task automatic step(input logic kf);
        key_flag = kf;
        @(posedge sys_clk);
        #1;
        key_flag = 1'b0;
    endtask

    // presses at edges set in mask (edge 0 = first step); results expected
    // after edges ra (num na) and rb (num nb), -1 meaning none
    task automatic run_seq(input string name, input logic [31:0] mask,
                           input int ra, input int na, input int rb, input int nb);
        int rf;
        int en;
        logic ev;
        rf = (rb >= 0) ? rb : ra;
        for (int e = 0; e <= rf + 2; e++) begin
            step(mask[e]);
            ev = (e == ra) || (e == rb);
            en = (e == ra) ? na : (e == rb) ? nb : 0;
            chk($sformatf("%s e%0d valid", name, e), {31'd0, click_valid}, {31'd0, ev});
            chk($sformatf("%s e%0d num", name, e), {30'd0, click_num}, en);
            if (e == 0) chk($sformatf("%s e0 busy", name), {31'd0, busy}, 1);
            if (e == rf) chk($sformatf("%s e%0d busy", name, e), {31'd0, busy}, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            key_flag = ~key_flag;
            @(posedge sys_clk);
            #1;
            chk_zero($sformatf("rst_hold%0d", i));
        end
        key_flag = 1'b0;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk_zero($sformatf("rst_rel%0d", i));
        end
        run_seq("single", 32'h1, 11, 1, -1, 0);
        run_seq("double", 32'h41, 17, 2, -1, 0);
        run_seq("triple", 32'h221, 20, 3, -1, 0);
        run_seq("five", 32'h11111, 27, 3, -1, 0);
        run_seq("gap_win", 32'h801, 22, 2, -1, 0);
        run_seq("gap_new", 32'h1001, 11, 1, 23, 1);
        step(1'b1);
        chk("mid busy", {31'd0, busy}, 1);
        for (int i = 1; i < 5; i++) step(1'b0);
        @(posedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        step(1'b0);
        step(1'b0);
        chk_zero("mid_rst_hold");
        sys_rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1'b0);
            chk($sformatf("post_rst%0d valid", i), {31'd0, click_valid}, 0);
        end
        run_seq("fresh", 32'h1, 11, 1, -1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_click_decoder.md
# key_click_decoder

Classifies the debounced key-press pulses from the key filter into single, double and triple clicks. It counts `key_flag` pulses whose spacing is within a programmable gap window. When the window expires with no further press, it emits one result pulse carrying the click count. It sits directly downstream of the key filter and feeds the LED/mode control logic.

## Interface
- `CNT_GAP`, default 25'd24_999_999 — maximum idle gap between presses, in `sys_clk` cycles minus 1 (500 ms at 50 MHz); must be ≥ 1.
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `key_flag`  in  1  one-cycle debounced press pulse from the key filter.
- `click_valid`  out  1  one-cycle pulse: a click sequence has completed.
- `click_num`  out  2  click count of the completed sequence; valid only while `click_valid`=1, otherwise 0.
  - 2'd1 single, 2'd2 double, 2'd3 triple-or-more.
- `busy`  out  1  high while a sequence is open (state WAIT).

## Operation
- Two-state FSM, IDLE and WAIT. Internal registers:
  - `cnt_gap` [24:0]
  - `click_cnt` [1:0]
- Reset values: state=IDLE, `cnt_gap`=0, `click_cnt`=0, `click_valid`=0, `click_num`=0, `busy`=0.
- IDLE:
  - `cnt_gap` held at 0.
  - `key_flag`=1 → WAIT, `click_cnt`←1, `cnt_gap`←0.
- WAIT:
  - `key_flag`=1 → `cnt_gap`←0, `click_cnt`←min(`click_cnt`+1, 3). A fourth or later press saturates at 3 and still restarts the window.
  - `key_flag`=0 and `cnt_gap`≠`CNT_GAP` → `cnt_gap`←`cnt_gap`+1.
  - `key_flag`=0 and `cnt_gap`==`CNT_GAP` → `click_valid`←1, `click_num`←`click_cnt`, state←IDLE, `cnt_gap`←0, `click_cnt`←0.
- Simultaneous events:
  - `key_flag`=1 in the same cycle as `cnt_gap`==`CNT_GAP`: the press wins. It is counted, the window restarts, and no result is emitted.
  - `key_flag`=1 in the cycle the FSM returns to IDLE (the cycle `click_valid` is high): starts a new sequence with `click_cnt`=1, `busy` high next cycle. The previous result is unaffected.
- Back-to-back `key_flag` pulses on consecutive cycles are each counted, even though the key filter never produces them.
- Asynchronous reset mid-sequence discards the open sequence; no `click_valid` is emitted.
- `cnt_gap` never exceeds `CNT_GAP`; no wrap-around is possible.

## Timing
- All outputs are registered; there is no combinational path from `key_flag`.
- `busy` rises on the edge that samples the first `key_flag`.
- Let edge t be the edge sampling the last press of a sequence:
  - `cnt_gap`=k after edge t+k.
  - `click_valid` goes high after edge t+`CNT_GAP`+1 and stays high for exactly one cycle.
  - `busy` falls on that same edge.
- Result latency from the last press is `CNT_GAP`+1 cycles.
- A press sampled at edge t+`CNT_GAP`+1 still counts as part of the open sequence (press-wins rule). A press at edge t+`CNT_GAP`+2 starts a new sequence.

## Structure
- Shared package `key_pkg`:
  - state encoding (IDLE=1'b0, WAIT=1'b1);
  - click codes CLICK_SINGLE=2'd1, CLICK_DOUBLE=2'd2, CLICK_TRIPLE=2'd3;
  - MAX_CLICKS=3.
- No sub-module. The key filter is instantiated beside this block at the top level, with its `key_flag` wired straight to this block's `key_flag`.

## Test plan
All scenarios use `CNT_GAP`=10.
- Reset: hold `sys_rst_n`=0 with `key_flag` toggling → all outputs 0. Release reset → all outputs remain 0 with no stimulus.
- Single press at edge 0 → `busy`=1 from edge 0; `click_valid`=1, `click_num`=1 for one cycle after edge 11; `busy`=0 after edge 11.
- Presses at edges 0 and 6 → `click_valid`, `click_num`=2 after edge 17. Presses at 0, 5 and 9 → `click_num`=3 after edge 20.
- Five presses 4 cycles apart (edges 0, 4, 8, 12, 16) → exactly one `click_valid`, `click_num`=3, after edge 27.
- Boundary: presses at edges 0 and 11 → one result, `click_num`=2, after edge 22. Presses at edges 0 and 12 → `click_num`=1 after edge 11, then `click_num`=1 after edge 23.
- Reset asserted at edge 5 after a press at edge 0 → no `click_valid` ever; `busy`=0 immediately. A press after release behaves as a fresh single click.
